// File: rtl/bridge_datatable_pkg.sv
// Shared constants and helpers for the bridge data-table RAM.
// Optional build macro used by the top: DATATABLE_OUTREG_EN (adds a second read register stage).
package bridge_datatable_pkg;

    localparam int DT_ADDR_W      = 10;
    localparam int DT_DATA_W      = 32;
    localparam int DT_SYNC_STAGES = 3;

    // Reverse the four bytes of a 32-bit word (bridge <-> core byte order)
    function automatic logic [DT_DATA_W-1:0] byte_swap(input logic [DT_DATA_W-1:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchronizer for a single asynchronous level signal.
// SYNC_STAGES must be at least 2; the output is the last flop of the chain.
module sync_ff_chain #(
    parameter int SYNC_STAGES = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_p;

    // Shift the asynchronous input through the flop chain, cleared by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_p[SYNC_STAGES-1];

endmodule

// File: rtl/bridge_datatable_ram.sv
// True dual-port data-table RAM between the core (port A, raw byte order)
// and the APF bridge command handler (port B, byte-swapped when the
// synchronized endian select is high).
// Optional build macro: DATATABLE_OUTREG_EN -- adds a second, reset-cleared
// output register on a_q and b_q (read latency 2 instead of 1).
// Byte swapping is only meaningful for DATA_W = 32.
module bridge_datatable_ram
    import bridge_datatable_pkg::*;
#(
    parameter int ADDR_W      = DT_ADDR_W,
    parameter int DATA_W      = DT_DATA_W,
    parameter int SYNC_STAGES = DT_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              endian_little,
    output logic              endian_little_s,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic              a_wren,
    input  logic [DATA_W-1:0] a_data,
    output logic [DATA_W-1:0] a_q,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              b_wren,
    input  logic [DATA_W-1:0] b_data,
    output logic [DATA_W-1:0] b_q
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              endian_s;
    logic              a_we;
    logic              b_we;
    logic              b_drop;
    logic [DATA_W-1:0] b_wr_word;
    logic [DATA_W-1:0] a_q_p0;
    logic [DATA_W-1:0] b_q_p0;
    logic [DATA_W-1:0] b_q_raw;

    sync_ff_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_endian_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d      (endian_little),
        .q      (endian_s)
    );

    assign endian_little_s = endian_s;

    // Writes are suppressed during reset; on a same-address collision the
    // core wins and the bridge write is dropped entirely.
    assign a_we      = a_wren & reset_n;
    assign b_drop    = a_we & (a_addr == b_addr);
    assign b_we      = b_wren & reset_n & ~b_drop;
    assign b_wr_word = endian_s ? byte_swap(b_data) : b_data;

    // RAM array write ports (contents are never reset)
    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_data;
        end
        if (b_we) begin
            mem[b_addr] <= b_wr_word;
        end
    end

    // ---- stage p0: read register, write-through on own port, old data cross-port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q_p0 <= '0;
            b_q_p0 <= '0;
        end else begin
            a_q_p0 <= a_we ? a_data : mem[a_addr];
            b_q_p0 <= b_we ? b_wr_word : mem[b_addr];
        end
    end

`ifdef DATATABLE_OUTREG_EN
    logic [DATA_W-1:0] a_q_p1;
    logic [DATA_W-1:0] b_q_p1;

    // ---- stage p1: optional output register for timing closure
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q_p1 <= '0;
            b_q_p1 <= '0;
        end else begin
            a_q_p1 <= a_q_p0;
            b_q_p1 <= b_q_p0;
        end
    end

    assign a_q     = a_q_p1;
    assign b_q_raw = b_q_p1;
`else
    assign a_q     = a_q_p0;
    assign b_q_raw = b_q_p0;
`endif

    // Bridge read data is swapped after the last register, following the live endian select
    assign b_q = endian_s ? byte_swap(b_q_raw) : b_q_raw;

endmodule

// File: tb/tb_bridge_datatable_ram.sv
// Scoreboard bench for bridge_datatable_ram: stimulus pushes expected reads,
// a monitor pops and compares them every cycle on the falling edge.
module tb_bridge_datatable_ram;

`ifdef DATATABLE_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int SYNC = 3;
    localparam int HMAX = 8192;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        endian_little = 1'b0;
    logic        endian_little_s;
    logic [9:0]  a_addr = '0;
    logic        a_wren = 1'b0;
    logic [31:0] a_data = '0;
    logic [31:0] a_q;
    logic [9:0]  b_addr = '0;
    logic        b_wren = 1'b0;
    logic [31:0] b_data = '0;
    logic [31:0] b_q;

    bridge_datatable_ram dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .endian_little  (endian_little),
        .endian_little_s(endian_little_s),
        .a_addr         (a_addr),
        .a_wren         (a_wren),
        .a_data         (a_data),
        .a_q            (a_q),
        .b_addr         (b_addr),
        .b_wren         (b_wren),
        .b_data         (b_data),
        .b_q            (b_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] a;
        bit          ak;
        logic [31:0] b;   // stored-order word; monitor applies the bridge view
        bit          bk;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mdl[int];
    bit          ein_hist[HMAX];
    bit          rst_hist[HMAX];
    int          edge_cnt = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    function automatic logic [31:0] swap32(input logic [31:0] x);
        return ((x & 32'h0000_00FF) << 24) | ((x & 32'h0000_FF00) << 8) |
               ((x & 32'h00FF_0000) >> 8)  | ((x & 32'hFF00_0000) >> 24);
    endfunction

    // Synchronized select after edge k: the input seen SYNC-1 edges earlier,
    // provided no reset occurred in that window.
    function automatic bit endian_after(input int k);
        if (k < SYNC) return 1'b0;
        for (int j = k - SYNC + 1; j <= k; j++) begin
            if (rst_hist[j]) return 1'b0;
        end
        return ein_hist[k - SYNC + 1];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %h expected %h", name, edge_cnt, act, exp);
        end
    endtask

    // Reference model step for the upcoming edge, using the inputs now driven
    task automatic apply();
        int          k;
        bit          es;
        bit          drop;
        logic [31:0] bw;
        exp_t        it;
        k = edge_cnt + 1;
        if (k >= HMAX) begin
            $display("FAIL history_overflow: got %0d expected below %0d", k, HMAX);
            $fatal(1, "history overflow");
        end
        ein_hist[k] = endian_little;
        rst_hist[k] = !reset_n;
        if (!reset_n) begin
            it = '{due: k, a: 32'h0, ak: 1'b1, b: 32'h0, bk: 1'b1};
            sbq.push_back(it);
            return;
        end
        if (LAT == 2 && (k == 1 || rst_hist[k-1])) begin
            it = '{due: k, a: 32'h0, ak: 1'b1, b: 32'h0, bk: 1'b1};
            sbq.push_back(it);
        end
        es   = endian_after(k - 1);
        bw   = es ? swap32(b_data) : b_data;
        drop = a_wren && b_wren && (a_addr == b_addr);
        it.due = k + LAT - 1;
        if (a_wren) begin
            it.a = a_data; it.ak = 1'b1;
        end else if (mdl.exists(int'(a_addr))) begin
            it.a = mdl[int'(a_addr)]; it.ak = 1'b1;
        end else begin
            it.a = 32'h0; it.ak = 1'b0;
        end
        if (b_wren && !drop) begin
            it.b = bw; it.bk = 1'b1;
        end else if (mdl.exists(int'(b_addr))) begin
            it.b = mdl[int'(b_addr)]; it.bk = 1'b1;
        end else begin
            it.b = 32'h0; it.bk = 1'b0;
        end
        if (a_wren) mdl[int'(a_addr)] = a_data;
        if (b_wren && !drop) mdl[int'(b_addr)] = bw;
        sbq.push_back(it);
    endtask

    task automatic cyc(input bit rn, input bit en,
                       input logic [9:0] aa, input bit aw, input logic [31:0] ad,
                       input logic [9:0] ba, input bit bw, input logic [31:0] bd);
        reset_n       = rn;
        endian_little = en;
        a_addr = aa; a_wren = aw; a_data = ad;
        b_addr = ba; b_wren = bw; b_data = bd;
        apply();
        @(negedge clk);
        #1;
    endtask

    // Monitor: count edges, compare endian select and due read data each cycle
    initial begin
        exp_t it;
        bit   es;
        forever begin
            @(posedge clk);
            edge_cnt++;
            @(negedge clk);
            es = endian_after(edge_cnt);
            chk("endian_little_s", {31'b0, endian_little_s}, {31'b0, es});
            while (sbq.size() > 0 && sbq[0].due < edge_cnt) begin
                it = sbq.pop_front();
                chk("sb_stale_entry", it.due, edge_cnt);
            end
            if (sbq.size() > 0 && sbq[0].due == edge_cnt) begin
                it = sbq.pop_front();
                if (it.ak) chk("a_q", a_q, it.a);
                if (it.bk) chk("b_q", b_q, es ? swap32(it.b) : it.b);
            end else begin
                chk("sb_missing_entry", 32'(sbq.size()), 32'hFFFF_FFFF);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit e;
        // Reset held over several edges
        repeat (3) cyc(0, 0, 10'h0, 0, 32'h0, 10'h0, 0, 32'h0);
        // Basic write A, read B (endian 0)
        cyc(1, 0, 10'h005, 1, 32'h1122_3344, 10'h000, 0, 32'h0);
        cyc(1, 0, 10'h000, 0, 32'h0,         10'h005, 0, 32'h0);
        cyc(1, 0, 10'h005, 0, 32'h0,         10'h005, 0, 32'h0);
        // Same-port write-through, address held
        cyc(1, 0, 10'h010, 1, 32'hCAFE_F00D, 10'h000, 0, 32'h0);
        cyc(1, 0, 10'h010, 0, 32'h0,         10'h000, 0, 32'h0);
        // Cross-port read during write returns old data
        cyc(1, 0, 10'h020, 1, 32'h0000_0001, 10'h000, 0, 32'h0);
        cyc(1, 0, 10'h020, 1, 32'h0000_0002, 10'h020, 0, 32'h0);
        cyc(1, 0, 10'h000, 0, 32'h0,         10'h020, 0, 32'h0);
        // Write collision: port A wins
        cyc(1, 0, 10'h030, 1, 32'hAAAA_0000, 10'h030, 1, 32'h0000_BBBB);
        cyc(1, 0, 10'h030, 0, 32'h0,         10'h030, 0, 32'h0);
        cyc(1, 0, 10'h030, 0, 32'h0,         10'h030, 0, 32'h0);
        // Endian select high: sync delay, then swapped bridge path
        repeat (5) cyc(1, 1, 10'h000, 0, 32'h0, 10'h000, 0, 32'h0);
        cyc(1, 1, 10'h000, 0, 32'h0, 10'h3FF, 1, 32'hAABB_CCDD);
        cyc(1, 1, 10'h3FF, 0, 32'h0, 10'h3FF, 0, 32'h0);
        cyc(1, 1, 10'h3FF, 0, 32'h0, 10'h3FF, 0, 32'h0);
        // Randomized traffic on a small window to provoke collisions
        e = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) e = ~e;
            cyc(1, e,
                10'(10'h100 + $urandom_range(0, 15)), bit'($urandom_range(0, 2) == 0), $urandom,
                10'(10'h100 + $urandom_range(0, 15)), bit'($urandom_range(0, 2) == 0), $urandom);
        end
        // Load a nonzero read, then reset mid-stream
        cyc(1, e, 10'h005, 0, 32'h0, 10'h005, 0, 32'h0);
        cyc(1, e, 10'h005, 0, 32'h0, 10'h005, 0, 32'h0);
        reset_n = 1'b0;
        #1;
        chk("reset_async_a_q", a_q, 32'h0);
        chk("reset_async_b_q", b_q, 32'h0);
        chk("reset_async_endian", {31'b0, endian_little_s}, 32'h0);
        sbq.delete();
        repeat (2) cyc(0, e, 10'h005, 1, 32'hDEAD_BEEF, 10'h005, 1, 32'hBEEF_DEAD);
        // Contents survive reset
        cyc(1, 0, 10'h005, 0, 32'h0, 10'h005, 0, 32'h0);
        repeat (4) cyc(1, 0, 10'h005, 0, 32'h0, 10'h005, 0, 32'h0);
        repeat (2) cyc(1, 0, 10'h030, 0, 32'h0, 10'h010, 0, 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bridge_datatable_ram.md
Name: bridge_datatable_ram

Overview:
- True dual-port 1024x32 data-table RAM sitting between the core (port A) and the APF bridge command handler (port B).
- Includes a 3-flop synchronizer for the asynchronous bridge endian-select line.
- When the synchronized line is high, port B write and read data are byte-swapped, so the bridge sees its native byte order.
- Port A is always raw.

Parameters:
- ADDR_W, 10, word address width (depth = 2**ADDR_W).
- DATA_W, 32, word width; byte-swap is defined only for 32.
- SYNC_STAGES, 3, synchronizer flop count; must be at least 2.

Ports:
- clk  in  1  single clock for both RAM ports and the synchronizer.
- reset_n  in  1  asynchronous active-low reset.
- endian_little  in  1  asynchronous byte-order select from the bridge.
- endian_little_s  out  1  synchronized endian_little.
- a_addr  in  ADDR_W  port A word address.
- a_wren  in  1  port A write enable.
- a_data  in  DATA_W  port A write data.
- a_q  out  DATA_W  port A read data.
- b_addr  in  ADDR_W  port B word address.
- b_wren  in  1  port B write enable.
- b_data  in  DATA_W  port B write data, in bridge byte order.
- b_q  out  DATA_W  port B read data, in bridge byte order.

Behaviour:
- Reset:
  - reset_n low asynchronously clears all synchronizer flops, a_q and b_q to 0.
  - Reset does not touch RAM contents; contents are undefined at power-up.
  - No writes occur while reset_n is low.
- Synchronizer:
  - endian_little passes through SYNC_STAGES flops; endian_little_s is the last flop.
  - A change on the input appears on the output after exactly SYNC_STAGES rising edges.
- Byte-swap:
  - The swap is swap(x) = {x[7:0], x[15:8], x[23:16], x[31:24]}.
  - When endian_little_s=1: the value stored is swap(b_data), and b_q = swap(stored word).
  - When endian_little_s=0: both paths are pass-through.
  - The swap on b_q is combinational on endian_little_s after the read register.
- Read latency:
  - 1 cycle. Address is sampled on rising edge N; q is valid after edge N, i.e. usable in cycle N+1.
  - q holds its value when the address is unchanged and no write occurs.
- Writes: take effect at the rising edge where wren=1.
- Same-port read-during-write: q shows the newly written data (write-through).
- Cross-port read-during-write, same address: the reading port returns the old data; the new data is visible on the next read.
- Simultaneous writes from both ports to the same address: port A (core) wins; the port B write is dropped.
- Different addresses: both ports operate fully independently every cycle.
- No address wrap handling is needed; addresses are full-width.

Optional Feature:
- Macro: DATATABLE_OUTREG_EN.
- When defined: an extra output register stage on a_q and b_q, so read latency is 2 cycles. The extra stage is also reset to 0 by reset_n. All read-during-write rules apply relative to the first stage.
- When undefined: 1-cycle latency as above.

Decomposition:
- Package bridge_datatable_pkg holds:
  - DT_ADDR_W=10, DT_DATA_W=32, DT_SYNC_STAGES=3;
  - a byte-swap function.
- One sub-module, sync_ff_chain:
  - parameterized SYNC_STAGES multi-flop synchronizer;
  - async active-low reset to 0;
  - instantiated once for endian_little.
- The RAM array is inferred in the top module.

Test Plan:
- Reset, then endian_little=0: write 0x11223344 to A@0x005; read B@0x005 -> b_q=0x11223344 one cycle later; a_q after reset=0.
- Set endian_little=1: endian_little_s rises after exactly 3 edges. Then write b_data=0xAABBCCDD at B@0x3FF; read A@0x3FF -> 0xDDCCBBAA; read B@0x3FF -> 0xAABBCCDD.
- Same-port read-during-write: A writes 0xCAFEF00D to 0x010 with a_addr held -> a_q=0xCAFEF00D next cycle.
- Cross-port read-during-write: 0x020 holds 0x1. A writes 0x2 there while B reads it -> b_q=0x1 that cycle; next B read gives 0x2.
- Write collision: A writes 0xAAAA0000 and B writes 0x0000BBBB to 0x030 in the same edge (endian 0) -> subsequent reads on both ports return 0xAAAA0000.
- Assert reset_n mid-stream while q is nonzero -> q=0 and endian_little_s=0 immediately. After release, 0x005 still reads 0x11223344. With DATATABLE_OUTREG_EN, all read latencies are 2.
